// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types for the TPU host sequencer.
//   cmd_op_e    - host command opcodes (WRITE, READ, RUN, reserved)
//   seq_state_e - sequencer FSM states
//   beat_addr() - 64-bit beat address (base + beat index, wraps modulo 2^64)
package tpu_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR        = 4'd1,
    S_RD_REQ    = 4'd2,
    S_RD_WAIT   = 4'd3,
    S_RD_HOLD   = 4'd4,
    S_RUN_START = 4'd5,
    S_POLL_REQ  = 4'd6,
    S_POLL_WAIT = 4'd7,
    S_FIN       = 4'd8
  } seq_state_e;

  function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [15:0] idx);
    return base + {48'd0, idx};
  endfunction

endpackage

// File: rtl/tpu_seq_rd_timer.sv
// tpu_seq_rd_timer: read-latency down-counter shared by the READ and POLL paths.
//   clk, rst  - clock, synchronous active-high reset
//   start_i   - high in the request cycle; loads RD_LATENCY-1
//   active_i  - high while waiting for read data
//   strobe_o  - high in the cycle where axi_rdata is valid and must be captured
// RD_LATENCY must be at least 1.
module tpu_seq_rd_timer #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic active_i,
  output logic strobe_o
);

  logic [15:0] cnt_q;

  // Load on request, count down while waiting, park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (start_i) begin
      cnt_q <= 16'(RD_LATENCY - 1);
    end else if (active_i && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign strobe_o = active_i && (cnt_q == 16'd0);

endmodule

// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: turns host commands into TPU slave-bus transactions.
//   cmd_*    - command handshake (op, 64-bit base address, 16-bit beat count)
//   wr_*     - write-beat stream (consumed only in WR)
//   rd_*     - read-beat stream (offered only in RD_HOLD)
//   axi_*    - TPU slave bus; address/data/we are zero whenever axi_req is low
//   busy, done (one-cycle pulse in FIN), err_timeout (sticky until next accept)
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 1,
  parameter logic [63:0] STATUS_ADDR  = 64'h0000_0000_0002_0000,
  parameter logic [63:0] START_VALUE  = 64'h1,
  parameter int unsigned FINISH_BIT   = 1,
  parameter int unsigned POLL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        axi_req,
  output logic        axi_we,
  output logic [63:0] axi_addr,
  output logic [63:0] axi_wdata,
  input  logic [63:0] axi_rdata,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  seq_state_e  state_q, state_d;
  logic [63:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] poll_q, poll_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic        axi_req_q, axi_req_d;
  logic        axi_we_q, axi_we_d;
  logic [63:0] axi_addr_q, axi_addr_d;
  logic [63:0] axi_wdata_q, axi_wdata_d;
  logic        cmd_ready_q, busy_q, done_q, wr_ready_q, rd_valid_q;
  logic        tmr_strobe_s;
  logic        wr_beat_s;

  tpu_seq_rd_timer #(.RD_LATENCY(RD_LATENCY)) u_rd_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  ((state_q == S_RD_REQ) || (state_q == S_POLL_REQ)),
    .active_i ((state_q == S_RD_WAIT) || (state_q == S_POLL_WAIT)),
    .strobe_o (tmr_strobe_s)
  );

  // A write beat is forwarded to the bus in the same cycle it is offered.
  assign wr_beat_s = wr_ready_q && wr_valid;

  // Next-state and datapath decisions.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    beat_d    = beat_q;
    poll_d    = poll_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d = cmd_addr;
          len_d  = cmd_len;
          beat_d = 16'd0;
          poll_d = 16'd0;
          err_d  = 1'b0;
          case (cmd_op_e'(cmd_op))
            OP_WRITE: state_d = (cmd_len == 16'd0) ? S_FIN : S_WR;
            OP_READ:  state_d = (cmd_len == 16'd0) ? S_FIN : S_RD_REQ;
            OP_RUN:   state_d = S_RUN_START;
            default:  state_d = S_FIN;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_beat_s) begin
          beat_d  = beat_q + 16'd1;
          state_d = (beat_q == len_q - 16'd1) ? S_FIN : S_WR;
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (tmr_strobe_s) begin
          rd_data_d = axi_rdata;
          state_d   = S_RD_HOLD;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          beat_d  = beat_q + 16'd1;
          state_d = (beat_q == len_q - 16'd1) ? S_FIN : S_RD_REQ;
        end else begin
          state_d = S_RD_HOLD;
        end
      end
      S_RUN_START: state_d = S_POLL_REQ;
      S_POLL_REQ:  state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (!tmr_strobe_s) begin
          state_d = S_POLL_WAIT;
        end else if (axi_rdata[FINISH_BIT]) begin
          state_d = S_FIN;
        end else if (poll_q + 16'd1 == 16'(POLL_TIMEOUT)) begin
          poll_d  = poll_q + 16'd1;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          poll_d  = poll_q + 16'd1;
          state_d = S_POLL_REQ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered bus request for the single-cycle request states, decoded from the next state.
  always_comb begin
    axi_req_d   = 1'b0;
    axi_we_d    = 1'b0;
    axi_addr_d  = 64'd0;
    axi_wdata_d = 64'd0;
    case (state_d)
      S_RD_REQ: begin
        axi_req_d  = 1'b1;
        axi_addr_d = beat_addr(base_d, beat_d);
      end
      S_RUN_START: begin
        axi_req_d   = 1'b1;
        axi_we_d    = 1'b1;
        axi_addr_d  = STATUS_ADDR;
        axi_wdata_d = START_VALUE;
      end
      S_POLL_REQ: begin
        axi_req_d  = 1'b1;
        axi_addr_d = STATUS_ADDR;
      end
      default: begin
        axi_req_d = 1'b0;
      end
    endcase
  end

  // FSM state, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= 64'd0;
      len_q       <= 16'd0;
      beat_q      <= 16'd0;
      poll_q      <= 16'd0;
      rd_data_q   <= 64'd0;
      err_q       <= 1'b0;
      axi_req_q   <= 1'b0;
      axi_we_q    <= 1'b0;
      axi_addr_q  <= 64'd0;
      axi_wdata_q <= 64'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      poll_q      <= poll_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      axi_req_q   <= axi_req_d;
      axi_we_q    <= axi_we_d;
      axi_addr_q  <= axi_addr_d;
      axi_wdata_q <= axi_wdata_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      wr_ready_q  <= (state_d == S_WR);
      rd_valid_q  <= (state_d == S_RD_HOLD);
    end
  end

  // The registered request fields are all zero in WR, so OR-ing in the write beat is safe.
  assign axi_req     = axi_req_q | wr_beat_s;
  assign axi_we      = axi_we_q | wr_beat_s;
  assign axi_addr    = wr_beat_s ? beat_addr(base_q, beat_q) : axi_addr_q;
  assign axi_wdata   = wr_beat_s ? wr_data : axi_wdata_q;

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_ready    = wr_ready_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_timeout = err_q;

endmodule
